rr_arb4_16bit: RTL and testbench

RR_ARB4_16BIT -- requirements
Module: rr_arb4_16bit

---
 rtl/rr_arb4_16bit.sv | 145 ++++++++++++++
 tb/tb_rr_arb4_16bit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_16bit.sv
// rr_arb4_16bit: four-channel, 16-bit round-robin arbiter with a one-word
// registered output slot and ready/valid handshake on the output.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   x0..x3   - channel data words
//   req      - per-channel valid (req[i] qualifies xi)
//   last     - per-channel end-of-packet marker (used only with RR_ARB_LOCK_EN)
//   ack      - combinational per-channel accept, at most one bit set
//   y        - registered selected word
//   y_valid  - y holds a word not yet taken downstream
//   y_ready  - downstream takes y this cycle
//   sel      - source channel index of the current y
//
// Optional feature: define RR_ARB_LOCK_EN to hold the grant on one channel
// until that channel presents a word with last set (packet lock).

module rr_arb4_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] x3,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    output logic [3:0]  ack,
    output logic [15:0] y,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [1:0]  sel
);

    localparam int unsigned DW = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned IW = 2;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   y_q, y_d;
    logic            y_valid_q, y_valid_d;

    logic [NCH-1:0]  eligible_c;
    logic [IW-1:0]   grant_c;
    logic            found_c;
    logic            slot_free_c;
    logic            load_c;
    logic [DW-1:0]   x_sel_c;

    // Eligible requests and cyclic priority search starting after ptr.
    always_comb begin
        eligible_c = req;
        grant_c    = ptr_q;
        found_c    = 1'b0;
        if (state_q == LOCK) begin
            eligible_c = req & (NCH'(1) << ptr_q);
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (!found_c && req[IW'(ptr_q + IW'(i))]) begin
                    grant_c = IW'(ptr_q + IW'(i));
                    found_c = 1'b1;
                end
            end
        end
    end

    // Reset gating keeps ack low while rst_n is asserted even with req high.
    assign slot_free_c = !y_valid_q || y_ready;
    assign load_c      = rst_n && slot_free_c && (|eligible_c);
    assign ack         = load_c ? (NCH'(1) << grant_c) : NCH'(0);

    always_comb begin
        unique case (grant_c)
            2'd0:    x_sel_c = x0;
            2'd1:    x_sel_c = x1;
            2'd2:    x_sel_c = x2;
            default: x_sel_c = x3;
        endcase
    end

    // Output slot and pointer update.
    always_comb begin
        y_d       = y_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        y_valid_d = y_valid_q;
        if (load_c) begin
            y_d       = x_sel_c;
            sel_d     = grant_c;
            ptr_d     = grant_c;
            y_valid_d = 1'b1;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

`ifdef RR_ARB_LOCK_EN
    // Packet lock: stay on a channel until it delivers a word marked last.
    always_comb begin
        state_d = state_q;
        if (load_c) begin
            if (state_q == ARB && !last[grant_c]) begin
                state_d = LOCK;
            end else if (state_q == LOCK && last[ptr_q]) begin
                state_d = ARB;
            end
        end
    end
`else
    logic unused_last_c;
    assign unused_last_c = ^last;

    always_comb begin
        state_d = ARB;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            ptr_q     <= 2'b11;
            sel_q     <= 2'b00;
            y_q       <= 16'h0000;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_rr_arb4_16bit.sv
// Directed bench for rr_arb4_16bit: reset, single channel, round-robin,
// backpressure, packet lock (build dependent) and idle gap.

module tb_rr_arb4_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] x0, x1, x2, x3;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [15:0] y;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  sel;

    int unsigned n_checks;
    int unsigned n_errors;

    rr_arb4_16bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .req     (req),
        .last    (last),
        .ack     (ack),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lock_ack [4];
    logic [1:0] lock_sel [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        x0 = 16'h1234; x1 = 16'h5678; x2 = 16'h9abc; x3 = 16'hdef0;
        req = 4'b1111; last = 4'b0000; y_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_y", 32'(y), 32'h0000);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        step();
        check("rst_ack_clk", 32'(ack), 32'd0);

        // Single channel, then asynchronous reset mid-stream.
        req = 4'b0000;
        rst_n = 1'b1;
        #1;
        check("post_rst_ack", 32'(ack), 32'd0);
        step();
        req = 4'b0100;
        #1;
        check("single_ack", 32'(ack), 32'b0100);
        step();
        check("single_y", 32'(y), 32'h9abc);
        check("single_sel", 32'(sel), 32'd2);
        check("single_valid", 32'(y_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_y", 32'(y), 32'h0000);
        check("midrst_valid", 32'(y_valid), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        step();

        // Round-robin with all channels requesting.
        req = 4'b1111;
        rst_n = 1'b1;
        #1;
        check("rr_ack0", 32'(ack), 32'b0001);
        step();
        check("rr_y0", 32'(y), 32'h1234); check("rr_sel0", 32'(sel), 32'd0);
        check("rr_ack1", 32'(ack), 32'b0010);
        step();
        check("rr_y1", 32'(y), 32'h5678); check("rr_sel1", 32'(sel), 32'd1);
        check("rr_ack2", 32'(ack), 32'b0100);
        step();
        check("rr_y2", 32'(y), 32'h9abc); check("rr_sel2", 32'(sel), 32'd2);
        check("rr_ack3", 32'(ack), 32'b1000);
        check("rr_valid", 32'(y_valid), 32'd1);
        step();
        check("rr_y3", 32'(y), 32'hdef0); check("rr_sel3", 32'(sel), 32'd3);
        check("rr_ack4", 32'(ack), 32'b0001);
        step();
        check("rr_y4", 32'(y), 32'h1234); check("rr_sel4", 32'(sel), 32'd0);

        // Backpressure: nothing moves while y is held.
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ack", 32'(ack), 32'd0);
            step();
            check("bp_y", 32'(y), 32'h1234);
            check("bp_sel", 32'(sel), 32'd0);
            check("bp_valid", 32'(y_valid), 32'd1);
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_ack", 32'(ack), 32'b0010);
        step();
        check("bp_release_y", 32'(y), 32'h5678);
        check("bp_release_sel", 32'(sel), 32'd1);

        // Packet lock on channel 0 (ptr=1, so channel 0 wins first).
`ifdef RR_ARB_LOCK_EN
        lock_ack[0] = 4'b0001; lock_ack[1] = 4'b0001; lock_ack[2] = 4'b0001; lock_ack[3] = 4'b0010;
        lock_sel[0] = 2'd0;    lock_sel[1] = 2'd0;    lock_sel[2] = 2'd0;    lock_sel[3] = 2'd1;
`else
        lock_ack[0] = 4'b0001; lock_ack[1] = 4'b0010; lock_ack[2] = 4'b0001; lock_ack[3] = 4'b0010;
        lock_sel[0] = 2'd0;    lock_sel[1] = 2'd1;    lock_sel[2] = 2'd0;    lock_sel[3] = 2'd1;
`endif
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            last = (k >= 2) ? 4'b0011 : 4'b0000;
            #1;
            check("lock_ack", 32'(ack), 32'(lock_ack[k]));
            step();
            check("lock_sel", 32'(sel), 32'(lock_sel[k]));
        end
        last = 4'b0000;

        // Idle gap: ptr ends at 3, so channel 0 is next.
        req = 4'b1000;
        #1;
        check("idle_ack3", 32'(ack), 32'b1000);
        step();
        check("idle_y3", 32'(y), 32'hdef0);
        check("idle_sel3", 32'(sel), 32'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_ack0", 32'(ack), 32'd0);
            step();
            check("idle_valid", 32'(y_valid), 32'd0);
            check("idle_sel_hold", 32'(sel), 32'd3);
        end
        req = 4'b1001;
        #1;
        check("idle_resume_ack", 32'(ack), 32'b0001);
        step();
        check("idle_resume_y", 32'(y), 32'h1234);
        check("idle_resume_sel", 32'(sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
